keypad_scanner: RTL and testbench

Parametrised keypad front end that drives one column of an R×C matrix keypad at a time and samples the row lines through a two-flop synchronizer. It debounces press and release, and emits a single-cycle strobe with the scan index of each new key press. The block replaces the purely combinational row/column decode: it owns column sequencing, synchronization, debounce and one-key lockout. Downstream logic maps the index to a character.

---
 rtl/keypad_scanner.sv | 132 +++++++++++++
 tb/tb_keypad_scanner.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Matrix keypad front end: column sequencing, row synchronisation, press/release
// debounce and one-key lockout, producing a strobed scan index per new key press.
module keypad_scanner #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    localparam int CODE_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ROWS-1:0]   rows,
    output logic [COLS-1:0]   cols,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held
);

    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W    = $clog2(COLS);
    localparam int DWELL_W  = $clog2(SCAN_DIV);
    localparam int STABLE_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t              state;
    logic [ROWS-1:0]     rows_m;
    logic [ROWS-1:0]     rows_s;
    logic [COL_W-1:0]    col_idx;
    logic [DWELL_W-1:0]  dwell;
    logic [STABLE_W-1:0] stable;
    logic [ROW_W-1:0]    r_cap;

    logic [ROW_W-1:0]    lowest_row;
    logic [COL_W-1:0]    col_idx_next;
    logic [COLS-1:0]     cols_next;
    logic [CODE_W-1:0]   code_calc;
    logic                sel;

    always_comb begin
        lowest_row = '0;
        // Walk from the top row down so the lowest set index is the last one written
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (rows_s[ROWS-1-i]) lowest_row = ROW_W'(ROWS - 1 - i);
        end
        col_idx_next = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
        cols_next    = {cols[COLS-2:0], cols[COLS-1]};
        code_calc    = CODE_W'(int'(r_cap) * COLS + int'(col_idx));
        sel          = rows_s[r_cap];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rows_m    <= '0;
            rows_s    <= '0;
            state     <= SCAN;
            cols      <= COLS'(1);
            col_idx   <= '0;
            dwell     <= '0;
            stable    <= '0;
            r_cap     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rows_m    <= rows;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell == DWELL_W'(SCAN_DIV - 1)) begin
                        dwell <= '0;
                        if (|rows_s) begin
                            r_cap  <= lowest_row;
                            stable <= '0;
                            state  <= DEBOUNCE;
                        end else begin
                            cols    <= cols_next;
                            col_idx <= col_idx_next;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (sel) begin
                        if (stable == STABLE_W'(DEBOUNCE_CYCLES - 1)) begin
                            key_code  <= code_calc;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            stable    <= '0;
                            state     <= HELD;
                        end else begin
                            stable <= stable + 1'b1;
                        end
                    end else begin
                        cols    <= cols_next;
                        col_idx <= col_idx_next;
                        stable  <= '0;
                        dwell   <= '0;
                        state   <= SCAN;
                    end
                end
                HELD: begin
                    if (!sel) begin
                        stable <= '0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!sel) begin
                        if (stable == STABLE_W'(DEBOUNCE_CYCLES - 1)) begin
                            key_held <= 1'b0;
                            cols     <= cols_next;
                            col_idx  <= col_idx_next;
                            stable   <= '0;
                            dwell    <= '0;
                            state    <= SCAN;
                        end else begin
                            stable <= stable + 1'b1;
                        end
                    end else begin
                        stable <= '0;
                        state  <= HELD;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a contact-matrix keypad model drives the rows and
// each scenario checks outcomes derived from the key position arithmetic.
module tb_keypad_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [COLS-1:0] contact [ROWS];

    int tests_run = 0;
    int tests_failed = 0;

    int   pulse_count = 0;
    int   last_code = -1;
    int   held_at_pulse = 0;
    int   onehot_bad = 0;
    int   frozen_bad = 0;
    int   long_pulse = 0;
    logic [3:0] prev_cols = 4'b0001;
    logic prev_held = 1'b0;
    logic prev_valid = 1'b0;

    keypad_scanner #(
        .ROWS(ROWS),
        .COLS(COLS),
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = '0;
        for (int r = 0; r < ROWS; r++) rows[r] = |(contact[r] & cols);
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (key_valid === 1'b1) begin
                pulse_count++;
                last_code = int'(key_code);
                held_at_pulse = int'(key_held);
                if (prev_valid === 1'b1) long_pulse++;
            end
            if (!$onehot(cols)) onehot_bad++;
            if (key_held === 1'b1 && prev_held === 1'b1 && cols !== prev_cols) frozen_bad++;
        end
        prev_cols  = cols;
        prev_held  = key_held;
        prev_valid = key_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, required to have finished");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++) contact[r] = '0;
    endtask

    task automatic wait_held(input logic level, output bit ok);
        int n = 0;
        while (key_held !== level && n < 200) begin
            cycles(1);
            n++;
        end
        ok = (key_held === level);
    endtask

    task automatic wait_cols(input logic [3:0] v, output bit ok);
        int n = 0;
        while (cols !== v && n < 100) begin
            cycles(1);
            n++;
        end
        ok = (cols === v);
    endtask

    task automatic test_reset();
        int base;
        logic [3:0] exp_cols;
        clear_keys();
        reset_n = 1'b0;
        cycles(3);
        tests_run++;
        if (cols !== 4'b0001) begin tests_failed++; $display("FAIL reset_cols: got %b expected 0001", cols); end
        tests_run++;
        if (key_code !== 4'd0) begin tests_failed++; $display("FAIL reset_code: got %0d expected 0", key_code); end
        tests_run++;
        if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        tests_run++;
        if (key_held !== 1'b0) begin tests_failed++; $display("FAIL reset_held: got %b expected 0", key_held); end
        @(negedge clk);
        reset_n = 1'b1;
        base = pulse_count;
        // After the k-th edge following release the column index is floor(k/4) mod 4
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_cols = 4'(1 << ((k / 4) % 4));
            tests_run++;
            if (cols !== exp_cols) begin
                tests_failed++;
                $display("FAIL idle_scan[%0d]: got %b expected %b", k, cols, exp_cols);
            end
        end
        tests_run++;
        if (pulse_count != base) begin tests_failed++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", pulse_count - base); end
    endtask

    task automatic test_clean_press();
        int base = pulse_count;
        bit ok;
        contact[2][1] = 1'b1;
        cycles(100);
        tests_run++;
        if (key_held !== 1'b1) begin tests_failed++; $display("FAIL clean_held: got %b expected 1", key_held); end
        tests_run++;
        if (cols !== 4'b0010) begin tests_failed++; $display("FAIL clean_cols: got %b expected 0010", cols); end
        contact[2][1] = 1'b0;
        wait_held(1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL clean_release: key_held %b expected 0 within bound", key_held); end
        cycles(5);
        tests_run++;
        if (pulse_count - base != 1) begin tests_failed++; $display("FAIL clean_pulses: got %0d expected 1", pulse_count - base); end
        tests_run++;
        if (last_code != 2 * COLS + 1) begin tests_failed++; $display("FAIL clean_code: got %0d expected %0d", last_code, 2 * COLS + 1); end
        tests_run++;
        if (held_at_pulse != 1) begin tests_failed++; $display("FAIL clean_held_at_pulse: got %0d expected 1", held_at_pulse); end
    endtask

    task automatic test_press_bounce();
        int base;
        bit ok;
        wait_cols(4'b0001, ok);
        wait_cols(4'b0010, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL bounce_sync: cols %b expected 0010 within bound", cols); end
        base = pulse_count;
        contact[2][1] = 1'b1;
        cycles(3);
        contact[2][1] = 1'b0;
        cycles(3);
        contact[2][1] = 1'b1;
        cycles(3);
        tests_run++;
        if (pulse_count != base) begin tests_failed++; $display("FAIL bounce_no_pulse: got %0d expected 0", pulse_count - base); end
        cycles(60);
        contact[2][1] = 1'b0;
        wait_held(1'b0, ok);
        cycles(5);
        tests_run++;
        if (pulse_count - base != 1) begin tests_failed++; $display("FAIL bounce_pulses: got %0d expected 1", pulse_count - base); end
        tests_run++;
        if (last_code != 9) begin tests_failed++; $display("FAIL bounce_code: got %0d expected 9", last_code); end
    endtask

    task automatic test_release_lockout();
        int base = pulse_count;
        bit ok;
        contact[0][3] = 1'b1;
        wait_held(1'b1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL lock_press: key_held %b expected 1 within bound", key_held); end
        contact[1][0] = 1'b1;
        cycles(20);
        tests_run++;
        if (pulse_count - base != 1) begin tests_failed++; $display("FAIL lock_no_second: got %0d expected 1", pulse_count - base); end
        tests_run++;
        if (cols !== 4'b1000) begin tests_failed++; $display("FAIL lock_cols: got %b expected 1000", cols); end
        contact[1][0] = 1'b0;
        cycles(3);
        contact[0][3] = 1'b0;
        cycles(4);
        contact[0][3] = 1'b1;
        cycles(2);
        contact[0][3] = 1'b0;
        cycles(4);
        tests_run++;
        if (key_held !== 1'b1) begin tests_failed++; $display("FAIL lock_bounce_held: got %b expected 1", key_held); end
        wait_held(1'b0, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL lock_release: key_held %b expected 0 within bound", key_held); end
        cycles(3);
        tests_run++;
        if (pulse_count - base != 1) begin tests_failed++; $display("FAIL lock_pulses: got %0d expected 1", pulse_count - base); end
        tests_run++;
        if (last_code != 3) begin tests_failed++; $display("FAIL lock_code: got %0d expected 3", last_code); end
        contact[1][0] = 1'b1;
        wait_held(1'b1, ok);
        cycles(10);
        contact[1][0] = 1'b0;
        wait_held(1'b0, ok);
        cycles(3);
        tests_run++;
        if (pulse_count - base != 2) begin tests_failed++; $display("FAIL lock_repress_pulses: got %0d expected 2", pulse_count - base); end
        tests_run++;
        if (last_code != 4) begin tests_failed++; $display("FAIL lock_repress_code: got %0d expected 4", last_code); end
    endtask

    task automatic test_simultaneous();
        int base = pulse_count;
        bit ok;
        contact[1][2] = 1'b1;
        contact[3][2] = 1'b1;
        wait_held(1'b1, ok);
        cycles(10);
        clear_keys();
        wait_held(1'b0, ok);
        cycles(3);
        tests_run++;
        if (pulse_count - base != 1) begin tests_failed++; $display("FAIL simul_pulses: got %0d expected 1", pulse_count - base); end
        tests_run++;
        if (last_code != 6) begin tests_failed++; $display("FAIL simul_code: got %0d expected 6", last_code); end
    endtask

    task automatic test_reset_mid_press();
        int base;
        int n = 0;
        bit ok;
        wait_cols(4'b0100, ok);
        wait_cols(4'b1000, ok);
        base = pulse_count;
        contact[3][3] = 1'b1;
        cycles(6);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (cols !== 4'b0001) begin tests_failed++; $display("FAIL midrst_cols: got %b expected 0001", cols); end
        tests_run++;
        if (key_code !== 4'd0) begin tests_failed++; $display("FAIL midrst_code: got %0d expected 0", key_code); end
        tests_run++;
        if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flags: got valid=%b held=%b expected 0 0", key_valid, key_held);
        end
        cycles(4);
        tests_run++;
        if (pulse_count != base) begin tests_failed++; $display("FAIL midrst_no_pulse: got %0d expected 0", pulse_count - base); end
        reset_n = 1'b1;
        while (pulse_count == base && n < 100) begin
            cycles(1);
            n++;
        end
        cycles(5);
        tests_run++;
        if (pulse_count - base != 1) begin tests_failed++; $display("FAIL midrst_pulses: got %0d expected 1", pulse_count - base); end
        tests_run++;
        if (last_code != 15) begin tests_failed++; $display("FAIL midrst_code_after: got %0d expected 15", last_code); end
        clear_keys();
        wait_held(1'b0, ok);
        cycles(3);
    endtask

    task automatic test_random();
        int base;
        int c;
        int mask;
        int lowest;
        int nb;
        int exp_code;
        bit ok;
        for (int it = 0; it < 10; it++) begin
            base = pulse_count;
            c = int'($urandom_range(0, COLS - 1));
            mask = int'($urandom_range(1, 15));
            lowest = 0;
            while (((mask >> lowest) & 1) == 0) lowest++;
            exp_code = lowest * COLS + c;
            nb = int'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                for (int r = 0; r < ROWS; r++) contact[r][c] = ((mask >> r) & 1) == 1;
                cycles(int'($urandom_range(1, 3)));
                clear_keys();
                cycles(int'($urandom_range(1, 3)));
            end
            for (int r = 0; r < ROWS; r++) contact[r][c] = ((mask >> r) & 1) == 1;
            cycles(int'($urandom_range(40, 70)));
            tests_run++;
            if (key_held !== 1'b1) begin tests_failed++; $display("FAIL rand_held[%0d]: got %b expected 1", it, key_held); end
            clear_keys();
            wait_held(1'b0, ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("FAIL rand_release[%0d]: key_held %b expected 0 within bound", it, key_held); end
            cycles(int'($urandom_range(3, 12)));
            tests_run++;
            if (pulse_count - base != 1) begin tests_failed++; $display("FAIL rand_pulses[%0d]: got %0d expected 1", it, pulse_count - base); end
            tests_run++;
            if (last_code != exp_code) begin tests_failed++; $display("FAIL rand_code[%0d]: got %0d expected %0d", it, last_code, exp_code); end
        end
    endtask

    initial begin
        clear_keys();
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_lockout();
        test_simultaneous();
        test_reset_mid_press();
        test_random();
        tests_run++;
        if (onehot_bad != 0) begin tests_failed++; $display("FAIL cols_onehot: got %0d bad cycles expected 0", onehot_bad); end
        tests_run++;
        if (frozen_bad != 0) begin tests_failed++; $display("FAIL cols_frozen: got %0d moves while held expected 0", frozen_bad); end
        tests_run++;
        if (long_pulse != 0) begin tests_failed++; $display("FAIL valid_width: got %0d multi-cycle pulses expected 0", long_pulse); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
